bcd_calc_seq: RTL and testbench
===============================

BCD_CALC_SEQ -- requirements
Module: bcd_calc_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clock port clk, reset port clr.
REQ-002 SHALL take parameter NDIG, default 4: number of BCD digits per operand (2..8).
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port clr, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port d_in, input, 4 bits: BCD digit; values 0..9 are valid.
REQ-006 SHALL have ports ent, pls, mns and eq, input, 1 bit each: digit-enter, add, subtract and equals commands.
REQ-007 SHALL have port q, output, 4*NDIG bits: display digits; digit 0 at [3:0].
REQ-008 SHALL have port q_ovf, output, 1 bit: carry-out digit of an addition (value 1).
REQ-009 SHALL have port qmin, output, 1 bit: result negative.
REQ-010 SHALL have port busy, output, 1 bit: calculation in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a result becomes valid.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse when an input is rejected.

Function
REQ-013 SHALL register ent, pls, mns and eq and act only on their rising edge (previous sample 0, current 1); a held level SHALL act once.
REQ-014 SHALL use states ENT_A, ENT_B, CALC, FIX and SHOW.
REQ-015 On ent in ENT_A/ENT_B with d_in<=9 and fewer than NDIG digits held, SHALL shift the current operand left one digit, insert d_in at digit 0, and mirror the operand on q.
REQ-016 SHALL ignore ent when NDIG digits are already held (no error); ent with d_in>9 SHALL leave state unchanged and pulse err.
REQ-017 pls or mns in ENT_A SHALL latch the operation, clear B, set q=0 and go to ENT_B; in ENT_B it SHALL only replace the operation.
REQ-018 eq in ENT_B SHALL go to CALC with busy=1; B with zero digits entered SHALL be treated as 0; eq in ENT_A SHALL be ignored.
REQ-019 SHALL pulse err and take no action when more than one of pls, mns and eq edges coincide; ent coinciding with any command SHALL be dropped and the command processed.
REQ-020 CALC SHALL process one digit per cycle, LSD first, over NDIG cycles; add: A_i+B_i+c with c0=0; sub: A_i+(9-B_i)+c with c0=1; digit sums >9 SHALL be corrected by +6.
REQ-021 At the end of CALC, add SHALL set q_ovf=final carry and enter SHOW; sub with final carry 1 SHALL enter SHOW with qmin=0.
REQ-022 At the end of CALC, sub with final carry 0 SHALL enter FIX, which tens-complements the result over NDIG cycles ((9-R_i)+c, c0=1), then set qmin=1 and enter SHOW.
REQ-023 Latency from the eq edge cycle to done SHALL be NDIG+1 cycles for add and non-negative sub, and 2*NDIG+1 cycles for negative sub.
REQ-024 done SHALL pulse one cycle on entry to SHOW; busy SHALL be 1 exactly in CALC and FIX.
REQ-025 q SHALL hold its last value during CALC/FIX and update on entry to SHOW.
REQ-026 All commands except clr SHALL be ignored in CALC/FIX, without err.
REQ-027 In SHOW, ent SHALL clear A, B, q_ovf and qmin and start ENT_A with this digit.
REQ-028 In SHOW, pls/mns SHALL chain (A=result, B cleared, ENT_B) only if qmin=0 and q_ovf=0; otherwise they SHALL be ignored with an err pulse.

Reset
REQ-029 clr SHALL asynchronously set state ENT_A, A=B=0, digit counts 0, q=0, q_ovf=0, qmin=0, busy=0, done=0, err=0 and edge registers 0, including mid-CALC/FIX.
REQ-030 SHALL accept ent on the first clock edge after clr deasserts.

Structure
REQ-031 Shared package calc_pkg SHALL hold the state enum, the op enum (OP_ADD, OP_SUB), BCD_MAX=9 and the NDIG default.
REQ-032 SHALL instantiate one sub-module, bcd_digit_alu: combinational one-digit BCD add with carry-in/out and an optional 9's-complement of operand B.

Verification (NDIG=4)
REQ-033 1,2,3,4 ent; pls; 5,6,7,8 ent; eq -> q=6912, q_ovf=0, done 5 cycles after eq.
REQ-034 9999 + 0001 -> q=0000, q_ovf=1, qmin=0; a following pls -> err pulse, state SHOW.
REQ-035 0123 - 0456 -> q=0333, qmin=1, done 9 cycles after eq.
REQ-036 Digits 1,2,3,4,5 -> q=1234 with no err; d_in=0xA ent -> err pulse, q unchanged.
REQ-037 0050 + 0025 = 0075; then mns, 0100, eq -> q=0025, qmin=1.
REQ-038 clr asserted on the 2nd CALC cycle -> all outputs 0 immediately; digit 7 entered next cycle -> q=0007.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the sequential BCD calculator
package calc_pkg;

  localparam int         NDIG_DEF = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  typedef enum logic [2:0] {
    ENT_A,
    ENT_B,
    CALC,
    FIX,
    SHOW
  } state_t;

  typedef enum logic {
    OP_ADD,
    OP_SUB
  } op_t;

endpackage

// File: rtl/bcd_digit_alu.sv
// rtl/bcd_digit_alu.sv - one-digit BCD adder with carry and optional 9's complement of B
module bcd_digit_alu (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic       i_comp,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_b;
  logic [4:0] w_raw;
  logic [4:0] w_corr;

  assign w_b    = i_comp ? (4'd9 - i_b) : i_b;
  assign w_raw  = {1'b0, i_a} + {1'b0, w_b} + {4'b0000, i_cin};
  // Binary sums above 9 skip the six unused codes to land back on a BCD digit.
  assign w_corr = w_raw + 5'd6;
  assign o_cout = (w_raw > 5'd9);
  assign o_sum  = o_cout ? w_corr[3:0] : w_raw[3:0];

endmodule

// File: rtl/bcd_calc_seq.sv
// rtl/bcd_calc_seq.sv - digit-serial BCD add/subtract calculator with keypad-style commands
module bcd_calc_seq
  import calc_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [3:0]        d_in,
  input  logic              ent,
  input  logic              pls,
  input  logic              mns,
  input  logic              eq,
  output logic [4*NDIG-1:0] q,
  output logic              q_ovf,
  output logic              qmin,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W  = 4 * NDIG;
  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(NDIG + 1);

  state_t          r_state, w_state_nxt;
  op_t             r_op, w_op_nxt;
  logic [W-1:0]    r_a, w_a_nxt, r_b, w_b_nxt, r_q, w_q_nxt, r_res, w_res_nxt, w_res_upd;
  logic [CW-1:0]   r_cnt_a, w_cnt_a_nxt, r_cnt_b, w_cnt_b_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            r_carry, w_carry_nxt;
  logic            r_ovf, w_ovf_nxt, r_min, w_min_nxt;
  logic            r_done, w_done_nxt, r_err, w_err_nxt;
  logic            r_ent_prev, r_pls_prev, r_mns_prev, r_eq_prev;
  logic            w_ent_rise, w_pls_rise, w_mns_rise, w_eq_rise, w_multi, w_digit_ok, w_last;
  logic [3:0]      w_alu_a, w_alu_b, w_alu_sum;
  logic            w_alu_cout, w_alu_comp;

  assign w_ent_rise = ent & ~r_ent_prev;
  assign w_pls_rise = pls & ~r_pls_prev;
  assign w_mns_rise = mns & ~r_mns_prev;
  assign w_eq_rise  = eq  & ~r_eq_prev;
  assign w_multi    = (w_pls_rise & w_mns_rise) | (w_pls_rise & w_eq_rise) | (w_mns_rise & w_eq_rise);
  assign w_digit_ok = (d_in <= BCD_MAX);
  assign w_last     = (r_idx == IW'(NDIG - 1));

  // FIX reuses the adder as (0 + (9 - R_i) + c) to tens-complement the stored result.
  assign w_alu_a    = (r_state == FIX) ? 4'd0 : r_a[r_idx*4 +: 4];
  assign w_alu_b    = (r_state == FIX) ? r_res[r_idx*4 +: 4] : r_b[r_idx*4 +: 4];
  assign w_alu_comp = (r_state == FIX) || (r_op == OP_SUB);

  bcd_digit_alu u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_cin  (r_carry),
    .i_comp (w_alu_comp),
    .o_sum  (w_alu_sum),
    .o_cout (w_alu_cout)
  );

  always_comb begin
    w_res_upd = r_res;
    w_res_upd[r_idx*4 +: 4] = w_alu_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_q_nxt     = r_q;
    w_res_nxt   = r_res;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_idx_nxt   = r_idx;
    w_carry_nxt = r_carry;
    w_ovf_nxt   = r_ovf;
    w_min_nxt   = r_min;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ENT_A, ENT_B: begin
        if (w_multi) begin
          w_err_nxt = 1'b1;
        end else if (w_pls_rise || w_mns_rise) begin
          w_op_nxt = w_pls_rise ? OP_ADD : OP_SUB;
          if (r_state == ENT_A) begin
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_q_nxt     = '0;
            w_state_nxt = ENT_B;
          end
        end else if (w_eq_rise) begin
          if (r_state == ENT_B) begin
            w_state_nxt = CALC;
            w_idx_nxt   = '0;
            w_res_nxt   = '0;
            w_carry_nxt = (r_op == OP_SUB);
          end
        end else if (w_ent_rise) begin
          if (!w_digit_ok) begin
            w_err_nxt = 1'b1;
          end else if (r_state == ENT_A && r_cnt_a < CW'(NDIG)) begin
            w_a_nxt     = {r_a[W-5:0], d_in};
            w_cnt_a_nxt = r_cnt_a + 1'b1;
            w_q_nxt     = {r_a[W-5:0], d_in};
          end else if (r_state == ENT_B && r_cnt_b < CW'(NDIG)) begin
            w_b_nxt     = {r_b[W-5:0], d_in};
            w_cnt_b_nxt = r_cnt_b + 1'b1;
            w_q_nxt     = {r_b[W-5:0], d_in};
          end
        end
      end
      CALC: begin
        w_res_nxt   = w_res_upd;
        w_carry_nxt = w_alu_cout;
        w_idx_nxt   = r_idx + 1'b1;
        if (w_last) begin
          if (r_op == OP_ADD || w_alu_cout) begin
            w_q_nxt     = w_res_upd;
            w_ovf_nxt   = (r_op == OP_ADD) && w_alu_cout;
            w_min_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = SHOW;
          end else begin
            w_idx_nxt   = '0;
            w_carry_nxt = 1'b1;
            w_state_nxt = FIX;
          end
        end
      end
      FIX: begin
        w_res_nxt   = w_res_upd;
        w_carry_nxt = w_alu_cout;
        w_idx_nxt   = r_idx + 1'b1;
        if (w_last) begin
          w_q_nxt     = w_res_upd;
          w_min_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (w_multi) begin
          w_err_nxt = 1'b1;
        end else if (w_pls_rise || w_mns_rise) begin
          // A negative or overflowed result cannot be carried into the next operation.
          if (r_min || r_ovf) begin
            w_err_nxt = 1'b1;
          end else begin
            w_op_nxt    = w_pls_rise ? OP_ADD : OP_SUB;
            w_a_nxt     = r_q;
            w_cnt_a_nxt = CW'(NDIG);
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_q_nxt     = '0;
            w_state_nxt = ENT_B;
          end
        end else if (w_ent_rise && !w_eq_rise) begin
          if (!w_digit_ok) begin
            w_err_nxt = 1'b1;
          end else begin
            w_a_nxt     = {{(W-4){1'b0}}, d_in};
            w_cnt_a_nxt = CW'(1);
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_q_nxt     = {{(W-4){1'b0}}, d_in};
            w_ovf_nxt   = 1'b0;
            w_min_nxt   = 1'b0;
            w_state_nxt = ENT_A;
          end
        end
      end
      default: w_state_nxt = ENT_A;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= ENT_A;
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_q        <= '0;
      r_res      <= '0;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_min      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ent_prev <= 1'b0;
      r_pls_prev <= 1'b0;
      r_mns_prev <= 1'b0;
      r_eq_prev  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_q        <= w_q_nxt;
      r_res      <= w_res_nxt;
      r_cnt_a    <= w_cnt_a_nxt;
      r_cnt_b    <= w_cnt_b_nxt;
      r_idx      <= w_idx_nxt;
      r_carry    <= w_carry_nxt;
      r_ovf      <= w_ovf_nxt;
      r_min      <= w_min_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_ent_prev <= ent;
      r_pls_prev <= pls;
      r_mns_prev <= mns;
      r_eq_prev  <= eq;
    end
  end

  assign q     = r_q;
  assign q_ovf = r_ovf;
  assign qmin  = r_min;
  assign done  = r_done;
  assign err   = r_err;
  assign busy  = (r_state == CALC) || (r_state == FIX);

endmodule

// File: tb/tb_bcd_calc_seq.sv
// tb/tb_bcd_calc_seq.sv - directed self-checking bench for bcd_calc_seq with NDIG=4
module tb_bcd_calc_seq;

  localparam int NDIG = 4;

  logic              clk = 1'b0;
  logic              clr, ent, pls, mns, eq;
  logic [3:0]        d_in;
  logic [4*NDIG-1:0] q;
  logic              q_ovf, qmin, busy, done, err;

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;

  bcd_calc_seq #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .clr   (clr),
    .d_in  (d_in),
    .ent   (ent),
    .pls   (pls),
    .mns   (mns),
    .eq    (eq),
    .q     (q),
    .q_ovf (q_ovf),
    .qmin  (qmin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err) err_seen++;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press_ent(input logic [3:0] d);
    d_in = d;
    ent  = 1'b1;
    tick();
    ent  = 1'b0;
    tick();
  endtask

  task automatic press_cmd(input logic p, input logic m, input logic e);
    pls = p;
    mns = m;
    eq  = e;
    tick();
    pls = 1'b0;
    mns = 1'b0;
    eq  = 1'b0;
    tick();
  endtask

  task automatic enter_num(input logic [15:0] v);
    for (int i = NDIG - 1; i >= 0; i--) press_ent(v[i*4 +: 4]);
  endtask

  task automatic run_eq(output int lat, output logic busy1);
    eq    = 1'b1;
    lat   = -1;
    busy1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin
        eq    = 1'b0;
        busy1 = busy;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  int   lat;
  logic b1;
  int   e0;

  initial begin
    clr = 1'b1; ent = 1'b0; pls = 1'b0; mns = 1'b0; eq = 1'b0; d_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_q", q, 16'h0000);
    check_val("reset_flags", {q_ovf, qmin, busy, done, err}, 5'b00000);
    clr = 1'b0;
    tick();

    // 1234 + 5678 = 6912
    enter_num(16'h1234);
    check_val("mirror_a", q, 16'h1234);
    press_cmd(1'b1, 1'b0, 1'b0);
    check_val("pls_clears_q", q, 16'h0000);
    enter_num(16'h5678);
    check_val("mirror_b", q, 16'h5678);
    run_eq(lat, b1);
    check_val("add_latency", lat, 5);
    check_val("add_busy", b1, 1'b1);
    check_val("add_q", q, 16'h6912);
    check_val("add_flags", {q_ovf, qmin}, 2'b00);
    tick();
    check_val("add_idle", {busy, done}, 2'b00);

    // 9999 + 0001 overflows; chaining then rejected
    enter_num(16'h9999);
    press_cmd(1'b1, 1'b0, 1'b0);
    enter_num(16'h0001);
    run_eq(lat, b1);
    check_val("ovf_latency", lat, 5);
    check_val("ovf_q", q, 16'h0000);
    check_val("ovf_flags", {q_ovf, qmin}, 2'b10);
    e0 = err_seen;
    press_cmd(1'b1, 1'b0, 1'b0);
    check_val("ovf_chain_err", err_seen - e0, 1);
    check_val("ovf_stays_show", {q_ovf, q}, {1'b1, 16'h0000});

    // 0123 - 0456 = -0333
    press_ent(4'd0);
    check_val("show_ent_clears_ovf", {q_ovf, q}, {1'b0, 16'h0000});
    press_ent(4'd1); press_ent(4'd2); press_ent(4'd3);
    press_cmd(1'b0, 1'b1, 1'b0);
    enter_num(16'h0456);
    run_eq(lat, b1);
    check_val("neg_latency", lat, 9);
    check_val("neg_busy", b1, 1'b1);
    check_val("neg_q", q, 16'h0333);
    check_val("neg_flags", {q_ovf, qmin}, 2'b01);

    // digit limit and invalid digit
    e0 = err_seen;
    press_ent(4'd1); press_ent(4'd2); press_ent(4'd3); press_ent(4'd4); press_ent(4'd5);
    check_val("full_q", q, 16'h1234);
    check_val("full_no_err", err_seen - e0, 0);
    press_ent(4'hA);
    check_val("bad_digit_err", err_seen - e0, 1);
    check_val("bad_digit_q", q, 16'h1234);

    // coincident commands rejected; eq ignored in ENT_A
    press_cmd(1'b1, 1'b1, 1'b0);
    check_val("multi_err", err_seen - e0, 2);
    check_val("multi_q", q, 16'h1234);
    press_cmd(1'b0, 1'b0, 1'b1);
    check_val("eq_in_a_q", {busy, q}, {1'b0, 16'h1234});
    check_val("eq_in_a_no_err", err_seen - e0, 2);

    // empty B treated as zero
    press_cmd(1'b1, 1'b0, 1'b0);
    run_eq(lat, b1);
    check_val("emptyb_latency", lat, 5);
    check_val("emptyb_q", q, 16'h1234);

    // 0050 + 0025 = 0075, chain - 0100 = -0025
    enter_num(16'h0050);
    press_cmd(1'b1, 1'b0, 1'b0);
    enter_num(16'h0025);
    run_eq(lat, b1);
    check_val("chain1_q", q, 16'h0075);
    e0 = err_seen;
    press_cmd(1'b0, 1'b1, 1'b0);
    check_val("chain_no_err", err_seen - e0, 0);
    enter_num(16'h0100);
    check_val("chain_b_q", q, 16'h0100);
    run_eq(lat, b1);
    check_val("chain2_latency", lat, 9);
    check_val("chain2_q", {qmin, q}, {1'b1, 16'h0025});
    press_cmd(1'b1, 1'b0, 1'b0);
    check_val("neg_chain_err", err_seen - e0, 1);

    // reset during second CALC cycle, then immediate entry
    press_ent(4'd5);
    press_cmd(1'b1, 1'b0, 1'b0);
    press_ent(4'd3);
    eq = 1'b1;
    tick();
    eq = 1'b0;
    check_val("calc_busy", busy, 1'b1);
    tick();
    clr = 1'b1;
    #1;
    check_val("clr_q", q, 16'h0000);
    check_val("clr_flags", {q_ovf, qmin, busy, done, err}, 5'b00000);
    #1;
    clr  = 1'b0;
    d_in = 4'd7;
    ent  = 1'b1;
    tick();
    ent  = 1'b0;
    check_val("post_clr_ent", q, 16'h0007);
    tick();

    // held ent acts once
    d_in = 4'd2;
    ent  = 1'b1;
    tick(); tick(); tick();
    ent  = 1'b0;
    tick();
    check_val("held_ent", q, 16'h0072);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
